// File: rtl/dxm_interrupt_event_gen_pkg.sv
// Shared definitions for the TRNG interrupt event generator: watchdog state encodings.
package dxm_interrupt_event_gen_pkg;

    typedef enum logic [1:0] {
        DxmTmoIdle = 2'd0,
        DxmTmoRun  = 2'd1,
        DxmTmoExp  = 2'd2
    } dxm_tmo_state_e;

endpackage

// File: rtl/dxm_event_tmo_fsm.sv
// Watchdog for TRNG collection runs: loads a count on start and flags a one-cycle timeout
// when the count runs out before done arrives.
module dxm_event_tmo_fsm
    import dxm_interrupt_event_gen_pkg::*;
#(
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tmo_start,
    input  logic             tmo_done,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic             tmo_fire,
    output logic             tmo_busy
);

    dxm_tmo_state_e   state_q;
    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= DxmTmoIdle;
            cnt_q    <= '0;
            tmo_fire <= 1'b0;
            tmo_busy <= 1'b0;
        end else begin
            tmo_fire <= 1'b0;
            case (state_q)
                DxmTmoIdle: begin
                    // done is meaningless without a run, so start always wins here
                    if (tmo_start) begin
                        state_q  <= DxmTmoRun;
                        cnt_q    <= tmo_limit;
                        tmo_busy <= 1'b1;
                    end
                end
                DxmTmoRun: begin
                    if (tmo_done) begin
                        state_q  <= DxmTmoIdle;
                        tmo_busy <= 1'b0;
                    end else if (tmo_start) begin
                        cnt_q <= tmo_limit;
                    end else if (cnt_q == '0) begin
                        tmo_fire <= 1'b1;
                        state_q  <= DxmTmoExp;
                        tmo_busy <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DxmTmoExp: begin
                    if (tmo_done) begin
                        state_q <= DxmTmoIdle;
                    end else if (tmo_start) begin
                        state_q  <= DxmTmoRun;
                        cnt_q    <= tmo_limit;
                        tmo_busy <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= DxmTmoIdle;
                    tmo_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dxm_interrupt_event_gen.sv
// Front end of the TRNG interrupt block: source edge/level events, ICR clear strobes and
// the collection watchdog timeout, all registered toward dxm_interrupt_low.
module dxm_interrupt_event_gen
    import dxm_interrupt_event_gen_pkg::*;
#(
    parameter int unsigned VEC_W   = 8,
    parameter int unsigned TMO_W   = 16,
    parameter int unsigned TMO_BIT = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VEC_W-1:0] src,
    input  logic [VEC_W-1:0] edge_sel,
    input  logic             reg_wr,
    input  logic             icr_sel,
    input  logic [VEC_W-1:0] reg_wdata,
    input  logic             tmo_start,
    input  logic             tmo_done,
    input  logic [TMO_W-1:0] tmo_limit,
    output logic [VEC_W-1:0] events_1p,
    output logic [VEC_W-1:0] r_din,
    output logic             clr_status_1p,
    output logic             tmo_busy
);

    logic [VEC_W-1:0] hist_q;
    logic [VEC_W-1:0] raw;
    logic [VEC_W-1:0] fire_vec;
    logic             tmo_fire;

    always_comb begin
        raw               = (src & ~hist_q & edge_sel) | (src & ~edge_sel);
        fire_vec          = '0;
        fire_vec[TMO_BIT] = tmo_fire;
    end

    // History resets to all ones so sources already high at release raise no edge event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q        <= '1;
            events_1p     <= '0;
            r_din         <= '0;
            clr_status_1p <= 1'b0;
        end else begin
            hist_q        <= src;
            events_1p     <= raw | fire_vec;
            clr_status_1p <= reg_wr & icr_sel;
            if (reg_wr && icr_sel) begin
                r_din <= reg_wdata;
            end
        end
    end

    dxm_event_tmo_fsm #(
        .TMO_W (TMO_W)
    ) u_tmo_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .tmo_start (tmo_start),
        .tmo_done  (tmo_done),
        .tmo_limit (tmo_limit),
        .tmo_fire  (tmo_fire),
        .tmo_busy  (tmo_busy)
    );

endmodule
